// File: rtl/traffic_light_monitor_if.sv
// Lamp observation bus between the traffic light controller side and the monitor.
// The master drives the lamps and clr_err; the slave (the monitor) drives the error outputs.
interface traffic_light_monitor_if;
    logic [2:0] light_M1;
    logic [2:0] light_S;
    logic [2:0] light_MT;
    logic [2:0] light_M2;
    logic       clr_err;
    logic       err_pulse;
    logic [1:0] err_class;
    logic [1:0] err_lamp;
    logic [3:0] err_sticky;
    logic [7:0] err_count;

    modport master (
        output light_M1, light_S, light_MT, light_M2, clr_err,
        input  err_pulse, err_class, err_lamp, err_sticky, err_count
    );

    modport slave (
        input  light_M1, light_S, light_MT, light_M2, clr_err,
        output err_pulse, err_class, err_lamp, err_sticky, err_count
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the four traffic lamps: flags encoding, conflict, sequence
// and dwell-time faults, with a sticky summary and a saturating fault-cycle count.
module traffic_light_monitor #(
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 2,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_YELLOW = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_light_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_RED     = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_GREEN   = 2'd3
    } lamp_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX_C    = '1;
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_GREEN_C  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_YELLOW_C = CNT_W'(MAX_YELLOW);

    function automatic lamp_state_e decode_lamp(input logic [2:0] v);
        lamp_state_e c;
        case (v)
            3'b100:  c = ST_RED;
            3'b010:  c = ST_YELLOW;
            3'b001:  c = ST_GREEN;
            default: c = ST_UNKNOWN;
        endcase
        return c;
    endfunction

    function automatic logic legal_step(input lamp_state_e from, input lamp_state_e to);
        return ((from == ST_GREEN)  && (to == ST_YELLOW)) ||
               ((from == ST_YELLOW) && (to == ST_RED))    ||
               ((from == ST_RED)    && (to == ST_GREEN));
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] idx;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    logic [2:0]       lamp_s     [4];
    lamp_state_e      colour_s   [4];
    lamp_state_e      state_r    [4];
    lamp_state_e      state_nx_s [4];
    logic [CNT_W-1:0] dwell_r    [4];
    logic [CNT_W-1:0] dwell_nx_s [4];
    logic [3:0]       enc_f_s;
    logic [3:0]       seq_f_s;
    logic [3:0]       tim_f_s;
    logic [3:0]       conf_f_s;
    logic [3:0]       open_s;
    logic [3:0]       green_s;
    logic [3:0]       det_s;
    logic             any_s;
    logic [1:0]       win_class_s;
    logic [1:0]       win_lamp_s;

    logic             err_pulse_r;
    logic [1:0]       err_class_r;
    logic [1:0]       err_lamp_r;
    logic [3:0]       err_sticky_r;
    logic [7:0]       err_count_r;

    assign lamp_s[0] = mon.light_M1;
    assign lamp_s[1] = mon.light_S;
    assign lamp_s[2] = mon.light_MT;
    assign lamp_s[3] = mon.light_M2;

    // Per-lamp FSM next state, dwell counter, encoding/sequence/timing faults.
    // A yellow overrun is caught while still yellow (dwell reaching MAX+1), so the
    // exit check only needs the lower bound.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            colour_s[i]   = decode_lamp(lamp_s[i]);
            enc_f_s[i]    = (colour_s[i] == ST_UNKNOWN);
            open_s[i]     = (colour_s[i] == ST_YELLOW) || (colour_s[i] == ST_GREEN);
            green_s[i]    = (colour_s[i] == ST_GREEN);
            seq_f_s[i]    = 1'b0;
            tim_f_s[i]    = 1'b0;
            state_nx_s[i] = state_r[i];
            dwell_nx_s[i] = dwell_r[i];
            if (enc_f_s[i]) begin
                state_nx_s[i] = ST_UNKNOWN;
                dwell_nx_s[i] = '0;
            end else if (colour_s[i] == state_r[i]) begin
                dwell_nx_s[i] = (dwell_r[i] == CNT_MAX_C) ? dwell_r[i] : dwell_r[i] + ONE_C;
                tim_f_s[i]    = (state_r[i] == ST_YELLOW) && (dwell_r[i] == MAX_YELLOW_C);
            end else begin
                state_nx_s[i] = colour_s[i];
                dwell_nx_s[i] = ONE_C;
                seq_f_s[i]    = (state_r[i] != ST_UNKNOWN) && !legal_step(state_r[i], colour_s[i]);
                tim_f_s[i]    = ((state_r[i] == ST_GREEN)  && (dwell_r[i] < MIN_GREEN_C)) ||
                                ((state_r[i] == ST_YELLOW) && (dwell_r[i] < MIN_YELLOW_C));
            end
        end
    end

    // Conflict pairs, attributed to the lower-indexed lamp of each pair.
    always_comb begin
        conf_f_s    = 4'b0000;
        conf_f_s[0] = open_s[1] & open_s[0];
        conf_f_s[1] = open_s[1] & (open_s[2] | open_s[3]);
        conf_f_s[2] = green_s[2] & open_s[3];
        conf_f_s[3] = 1'b0;
    end

    assign det_s = {|tim_f_s, |seq_f_s, |conf_f_s, |enc_f_s};
    assign any_s = |det_s;

    // Highest-priority class and lowest lamp index within it.
    always_comb begin
        win_class_s = 2'd0;
        win_lamp_s  = 2'd0;
        if (|enc_f_s) begin
            win_class_s = 2'd0;
            win_lamp_s  = lowest_idx(enc_f_s);
        end else if (|conf_f_s) begin
            win_class_s = 2'd1;
            win_lamp_s  = lowest_idx(conf_f_s);
        end else if (|seq_f_s) begin
            win_class_s = 2'd2;
            win_lamp_s  = lowest_idx(seq_f_s);
        end else if (|tim_f_s) begin
            win_class_s = 2'd3;
            win_lamp_s  = lowest_idx(tim_f_s);
        end else begin
            win_class_s = 2'd0;
            win_lamp_s  = 2'd0;
        end
    end

    // Lamp FSM state and dwell registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= ST_UNKNOWN;
                dwell_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= state_nx_s[i];
                dwell_r[i] <= dwell_nx_s[i];
            end
        end
    end

    // Error reporting registers; a fault on the clearing edge survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pulse_r  <= 1'b0;
            err_class_r  <= 2'd0;
            err_lamp_r   <= 2'd0;
            err_sticky_r <= 4'b0000;
            err_count_r  <= 8'd0;
        end else begin
            err_pulse_r <= any_s;
            err_class_r <= win_class_s;
            err_lamp_r  <= win_lamp_s;
            if (mon.clr_err) begin
                err_sticky_r <= det_s;
                err_count_r  <= any_s ? 8'd1 : 8'd0;
            end else begin
                err_sticky_r <= err_sticky_r | det_s;
                if (any_s && (err_count_r != 8'hFF)) begin
                    err_count_r <= err_count_r + 8'd1;
                end else begin
                    err_count_r <= err_count_r;
                end
            end
        end
    end

    assign mon.err_pulse  = err_pulse_r;
    assign mon.err_class  = err_class_r;
    assign mon.err_lamp   = err_lamp_r;
    assign mon.err_sticky = err_sticky_r;
    assign mon.err_count  = err_count_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    traffic_light_monitor_if bus ();

    traffic_light_monitor #(
        .CNT_W     (8),
        .MIN_GREEN (2),
        .MIN_YELLOW(2),
        .MAX_YELLOW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic pulse, input logic [1:0] cls,
                              input logic [1:0] lamp, input logic [3:0] sticky,
                              input logic [7:0] count);
        check_eq({tag, ".pulse"},  32'(bus.err_pulse),  32'(pulse));
        check_eq({tag, ".class"},  32'(bus.err_class),  32'(cls));
        check_eq({tag, ".lamp"},   32'(bus.err_lamp),   32'(lamp));
        check_eq({tag, ".sticky"}, 32'(bus.err_sticky), 32'(sticky));
        check_eq({tag, ".count"},  32'(bus.err_count),  32'(count));
    endtask

    // Apply one sample, clock it in, and leave time just past the edge for sampling.
    task automatic step(input logic [2:0] m1, input logic [2:0] s, input logic [2:0] mt,
                        input logic [2:0] m2, input logic clr);
        bus.light_M1 = m1;
        bus.light_S  = s;
        bus.light_MT = mt;
        bus.light_M2 = m2;
        bus.clr_err  = clr;
        @(posedge clk);
        #1;
        bus.clr_err  = 1'b0;
    endtask

    task automatic run_quiet(input string tag, input logic [2:0] m1, input logic [2:0] s,
                             input logic [2:0] mt, input logic [2:0] m2, input int n);
        for (int k = 0; k < n; k++) begin
            step(m1, s, mt, m2, 1'b0);
            check_eq(tag, 32'(bus.err_pulse), 32'd0);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        bus.light_M1 = R;
        bus.light_S  = R;
        bus.light_MT = R;
        bus.light_M2 = R;
        bus.clr_err  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_all("reset", 1'b0, 2'd0, 2'd0, 4'b0000, 8'd0);
        rst = 1'b1;

        // Normal controller cycle
        run_quiet("normal_m_green",  G, R, R, G, 5);
        run_quiet("normal_m2_yel",   G, R, R, Y, 3);
        run_quiet("normal_mt_green", G, R, G, R, 3);
        run_quiet("normal_m1mt_yel", Y, R, Y, R, 3);
        run_quiet("normal_s_green",  R, G, R, R, 4);
        run_quiet("normal_s_yel",    R, Y, R, R, 3);
        check_eq("normal_sticky", 32'(bus.err_sticky), 32'd0);
        check_eq("normal_count",  32'(bus.err_count),  32'd0);
        run_quiet("back_to_m1", G, R, R, R, 1);

        // Conflict: S green with M1 green
        step(G, G, R, R, 1'b0);
        expect_all("conflict", 1'b1, 2'd1, 2'd0, 4'b0010, 8'd1);
        // S green->red after one cycle: sequence (and timing), lamp S
        step(G, R, R, R, 1'b0);
        expect_all("s_green_red", 1'b1, 2'd2, 2'd1, 4'b1110, 8'd2);
        step(G, R, R, R, 1'b1);
        expect_all("clear1", 1'b0, 2'd0, 2'd0, 4'b0000, 8'd0);

        // Sequence + timing on M1: short green then straight to red
        run_quiet("m1_prep_y", Y, R, R, R, 2);
        run_quiet("m1_prep_r", R, R, R, R, 2);
        run_quiet("m1_prep_g", G, R, R, R, 1);
        step(R, R, R, R, 1'b0);
        expect_all("seq_timing", 1'b1, 2'd2, 2'd0, 4'b1100, 8'd1);
        step(R, R, R, R, 1'b1);
        expect_all("clear2", 1'b0, 2'd0, 2'd0, 4'b0000, 8'd0);

        // Encoding faults on S and MT in the same sample
        step(R, 3'b000, 3'b011, R, 1'b0);
        expect_all("encoding", 1'b1, 2'd0, 2'd1, 4'b0001, 8'd1);
        // Recovery from UNKNOWN is untimed and unsequenced; clear on the same edge
        step(R, R, R, R, 1'b1);
        expect_all("enc_recover", 1'b0, 2'd0, 2'd0, 4'b0000, 8'd0);

        // Yellow overrun on M2
        run_quiet("m2_green", R, R, R, G, 2);
        for (int k = 0; k < 6; k++) begin
            step(R, R, R, Y, 1'b0);
            check_eq("overrun_pulse", 32'(bus.err_pulse), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) begin
                check_eq("overrun_class", 32'(bus.err_class), 32'd3);
                check_eq("overrun_lamp",  32'(bus.err_lamp),  32'd3);
            end
        end
        step(R, R, R, R, 1'b0);
        expect_all("overrun_exit", 1'b0, 2'd0, 2'd0, 4'b1000, 8'd1);

        // Clear, then reset mid-green
        step(R, R, R, R, 1'b1);
        expect_all("clear3", 1'b0, 2'd0, 2'd0, 4'b0000, 8'd0);
        step(G, R, R, R, 1'b0);
        step(R, G, R, R, 1'b0);
        check_eq("pre_reset_pulse", 32'(bus.err_pulse), 32'd1);
        rst = 1'b0;
        #1;
        expect_all("async_reset", 1'b0, 2'd0, 2'd0, 4'b0000, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(R, R, R, R, 1'b0);
        expect_all("post_reset", 1'b0, 2'd0, 2'd0, 4'b0000, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
